muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a combinational product.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_e_i,
    input  logic [2:0]      op_e_i,
    input  logic [XLEN-1:0] a_e_i,
    input  logic [XLEN-1:0] b_e_i,
    input  logic            flush_e_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state;
    logic [5:0]        cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              neg_rem_q;

    logic              a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   mul_res, div_res;

    function automatic logic [XLEN-1:0] mul_fix(input logic [2*XLEN-1:0] p, input logic neg,
                                                input logic [2:0] op);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return (op == 3'd0) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
    endfunction

    always_comb begin
        a_signed    = (op_e_i == 3'd1) || (op_e_i == 3'd2) || (op_e_i == 3'd4) || (op_e_i == 3'd6);
        b_signed    = (op_e_i == 3'd1) || (op_e_i == 3'd4) || (op_e_i == 3'd6);
        neg_a       = a_signed & a_e_i[XLEN-1];
        neg_b       = b_signed & b_e_i[XLEN-1];
        a_mag       = neg_a ? -a_e_i : a_e_i;
        b_mag       = neg_b ? -b_e_i : b_e_i;
        div_zero    = op_e_i[2] && (b_e_i == '0);
        div_ovf     = op_e_i[2] && !op_e_i[0] && (a_e_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_e_i == '1);
        special_res = div_zero ? (op_e_i[1] ? a_e_i : '1)
                               : (op_e_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

        // Multiplier sits in acc's low half and shifts out as the product shifts in.
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};

        // acc = {partial remainder, dividend/quotient}; quotient bits enter at the bottom.
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift[XLEN-1:0] - opb;
        div_next  = (div_shift >= {1'b0, opb}) ? {div_diff, acc[XLEN-2:0], 1'b1}
                                               : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};

        mul_res = mul_fix(mul_next, neg_q, op_q);
        if (op_q[1])
            div_res = neg_rem_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        else
            div_res = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    assign busy_o = rst_n_i && (((state == S_IDLE) && start_e_i && !flush_e_i) ||
                                (state == S_MUL) || (state == S_DIV));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            opb       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            done_o    <= 1'b0;
            result_o  <= '0;
        end else begin
            done_o <= 1'b0;
            if (flush_e_i) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_e_i) begin
                            op_q      <= op_e_i;
                            opb       <= b_mag;
                            acc       <= {{XLEN{1'b0}}, a_mag};
                            neg_q     <= neg_a ^ neg_b;
                            neg_rem_q <= neg_a;
                            cnt       <= '0;
                            if (div_zero || div_ovf) begin
                                state    <= S_DONE;
                                done_o   <= 1'b1;
                                result_o <= special_res;
`ifdef MULDIV_FAST_MUL_EN
                            end else if (!op_e_i[2]) begin
                                state    <= S_DONE;
                                done_o   <= 1'b1;
                                result_o <= mul_fix(fast_prod, neg_a ^ neg_b, op_e_i);
`endif
                            end else begin
                                state <= op_e_i[2] ? S_DIV : S_MUL;
                            end
                        end
                    end
                    S_MUL: begin
                        acc <= mul_next;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'(XLEN-1)) begin
                            state    <= S_DONE;
                            done_o   <= 1'b1;
                            result_o <= mul_res;
                            cnt      <= '0;
                        end
                    end
                    S_DIV: begin
                        acc <= div_next;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'(XLEN-1)) begin
                            state    <= S_DONE;
                            done_o   <= 1'b1;
                            result_o <= div_res;
                            cnt      <= '0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule
